// File: rtl/tx_nrzi_serializer_pkg.sv
// Shared types and defaults for the NRZI transmit path.
// Holds the FSM state encoding, parameter defaults and the line idle level.
package tx_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_CLKS_PER_BIT = 8;
  localparam int DEF_STUFF_LIMIT  = 6;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STUFF = 2'd2
  } tx_state_e;

  // NRZI: a 0 toggles the line, a 1 holds it.
  function automatic logic nrzi_next(input logic level, input logic b);
    return b ? level : ~level;
  endfunction

endpackage

// File: rtl/tx_nrzi_serializer_if.sv
// FIFO read port between tx_fifo (slave side) and the serializer (master side).
// First-word-fall-through: read_data is valid whenever fifo_empty is low.
interface tx_nrzi_serializer_if
  import tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_enable;

  modport master (input fifo_empty, input read_data, output read_enable);
  modport slave  (output fifo_empty, output read_data, input read_enable);
endinterface

// File: rtl/tx_nrzi_serializer_bit_timer.sv
// Bit-period timer: clear restarts a period, period_start is registered and high
// in the first cycle of each period, period_end marks its last cycle. No backpressure.
module tx_bit_timer
  import tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic period_start,
  output logic period_end
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic          start_q, start_d;

  assign period_end   = enable && (clk_cnt_q == LAST);
  assign period_start = start_q;

  always_comb begin
    clk_cnt_d = clk_cnt_q;
    start_d   = clear;
    if (clear || !enable || period_end) begin
      clk_cnt_d = '0;
    end else begin
      clk_cnt_d = clk_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt_q <= '0;
      start_q   <= 1'b0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      start_q   <= start_d;
    end
  end

endmodule

// File: rtl/tx_nrzi_serializer.sv
// Pops bytes from the FWFT FIFO and sends them LSB-first with bit stuffing and NRZI;
// bit 0 reaches the line 1 cycle after the pop; pops only when tx_enable and the FIFO is non-empty.
module tx_nrzi_serializer
  import tx_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int STUFF_LIMIT  = DEF_STUFF_LIMIT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tx_enable,
  tx_nrzi_serializer_if.master         fifo,
  output logic                         serial_out,
  output logic                         bit_strobe,
  output logic                         tx_busy
);

  localparam int            OW       = $clog2(STUFF_LIMIT + 1);
  localparam int            IW       = $clog2(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LIMIT);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic [OW-1:0]         ones_cnt_q, ones_cnt_d;
  logic                  serial_q, serial_d;

  logic period_end, period_start;
  logic can_pop, byte_done;
  logic pop, adv, enter, send_bit;

  assign can_pop   = tx_enable && !fifo.fifo_empty;
  assign byte_done = (bit_idx_q == LAST_BIT);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    ones_cnt_d = ones_cnt_q;
    serial_d   = serial_q;
    pop        = 1'b0;
    adv        = 1'b0;
    enter      = 1'b0;
    send_bit   = 1'b0;

    case (state_q)
      IDLE: begin
        if (can_pop) pop = 1'b1;
      end
      SHIFT: begin
        if (period_end) begin
          if (ones_cnt_q == ONES_MAX) begin
            state_d = STUFF;
            enter   = 1'b1;
          end else if (!byte_done) begin
            adv = 1'b1;
          end else if (can_pop) begin
            pop = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      STUFF: begin
        // bit_idx still points at the last data bit sent before the stuff
        if (period_end) begin
          if (!byte_done)   adv = 1'b1;
          else if (can_pop) pop = 1'b1;
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      state_d   = SHIFT;
      shift_d   = fifo.read_data;
      bit_idx_d = '0;
      send_bit  = fifo.read_data[0];
      enter     = 1'b1;
    end else if (adv) begin
      state_d   = SHIFT;
      shift_d   = shift_q >> 1;
      bit_idx_d = bit_idx_q + 1'b1;
      send_bit  = shift_q[1];
      enter     = 1'b1;
    end

    if (enter) begin
      serial_d   = nrzi_next(serial_q, send_bit);
      ones_cnt_d = send_bit ? ones_cnt_q + 1'b1 : '0;
    end else if (state_d == IDLE) begin
      ones_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      ones_cnt_q <= '0;
      serial_q   <= LINE_IDLE;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      ones_cnt_q <= ones_cnt_d;
      serial_q   <= serial_d;
    end
  end

  tx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clear        (enter),
    .enable       (tx_busy),
    .period_start (period_start),
    .period_end   (period_end)
  );

  assign fifo.read_enable = pop && !rst;
  assign serial_out       = serial_q;
  assign bit_strobe       = period_start;
  assign tx_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_tx_nrzi_serializer.sv
// Directed bench for tx_nrzi_serializer: a bit-stream model (stuffing + NRZI per period)
// predicts the line every cycle; literal counts pin the model to hand-computed values.
module tb_tx_nrzi_serializer;
  import tx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_enable = 1'b0;
  logic serial_out, bit_strobe, tx_busy;

  tx_nrzi_serializer_if fif ();

  tx_nrzi_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .tx_enable  (tx_enable),
    .fifo       (fif.master),
    .serial_out (serial_out),
    .bit_strobe (bit_strobe),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] fq[$];
  logic [7:0] mb[$];
  logic exp_ser [600];
  logic exp_stb [600];
  logic exp_busy[600];
  logic exp_re  [600];
  logic line_lvl = 1'b1;
  bit   chk_on = 1'b0;
  int   cyc = 0;
  int   chk_len = 0;
  int   n_re, n_busy, n_stb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    fif.fifo_empty = (fq.size() == 0);
    fif.read_data  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  // Expand bytes into line periods, then into a per-cycle waveform.
  // Cycle 0 is the idle cycle holding the first pop; period p spans cycles 8p+1..8p+8.
  task automatic build_model(output int periods);
    logic lv[$];
    bit   first[$];
    int   ones = 0;
    logic l = line_lvl;
    for (int j = 0; j < mb.size(); j++) begin
      logic [7:0] bv = mb[j];
      for (int i = 0; i < 8; i++) begin
        if (bv[i]) ones++;
        else begin ones = 0; l = ~l; end
        lv.push_back(l);
        first.push_back(i == 0);
        if (ones == 6) begin
          ones = 0;
          l = ~l;
          lv.push_back(l);
          first.push_back(1'b0);
        end
      end
    end
    periods = lv.size();
    for (int c = 0; c < 8 * periods + 3; c++) begin
      if (c == 0) begin
        exp_ser[c] = line_lvl; exp_stb[c] = 1'b0; exp_busy[c] = 1'b0; exp_re[c] = 1'b1;
      end else if (c <= 8 * periods) begin
        exp_ser[c]  = lv[(c - 1) / 8];
        exp_stb[c]  = ((c - 1) % 8 == 0);
        exp_busy[c] = 1'b1;
        exp_re[c]   = (c % 8 == 0) && (c / 8 < periods) && first[c / 8];
      end else begin
        exp_ser[c] = lv[periods - 1]; exp_stb[c] = 1'b0; exp_busy[c] = 1'b0; exp_re[c] = 1'b0;
      end
    end
    chk_len  = 8 * periods + 3;
    line_lvl = lv[periods - 1];
  endtask

  // Single compare process against the model, plus a global pop-legality guard.
  always @(negedge clk) begin
    if (chk_on && cyc < chk_len) begin
      chk($sformatf("c%0d serial_out", cyc), serial_out, exp_ser[cyc]);
      chk($sformatf("c%0d bit_strobe", cyc), bit_strobe, exp_stb[cyc]);
      chk($sformatf("c%0d tx_busy", cyc), tx_busy, exp_busy[cyc]);
      chk($sformatf("c%0d read_enable", cyc), fif.read_enable, exp_re[cyc]);
      if (fif.read_enable === 1'b1) n_re++;
      if (tx_busy === 1'b1) n_busy++;
      if (bit_strobe === 1'b1) n_stb++;
      cyc++;
    end
    if (fif.read_enable === 1'b1) chk("pop_legal", fif.fifo_empty | rst, 0);
  end

  // Called at posedge+1: runs chk_len cycles, servicing FIFO pops.
  task automatic run_scn(input int drop_at, input int rst_at);
    logic re;
    n_re = 0; n_busy = 0; n_stb = 0;
    cyc = 0;
    chk_on = 1'b1;
    for (int k = 0; k < chk_len; k++) begin
      @(negedge clk);
      re = fif.read_enable;
      @(posedge clk);
      #1;
      if (re === 1'b1 && fq.size() != 0) void'(fq.pop_front());
      drive_fifo();
      if (k + 1 == drop_at) tx_enable = 1'b0;
      if (k + 1 == rst_at) rst = 1'b1;
    end
    chk_on = 1'b0;
  endtask

  task automatic start_scn(input int drop_at, input int rst_at);
    int p;
    foreach (mb[i]) fq.push_back(mb[i]);
    drive_fifo();
    tx_enable = 1'b1;
    build_model(p);
    if (rst_at != 0) chk_len = rst_at + 1;
    run_scn(drop_at, rst_at);
    tx_enable = 1'b0;
  endtask

  initial begin
    int p;
    // Reset with a byte waiting and tx_enable high
    fq.push_back(8'h00);
    drive_fifo();
    tx_enable = 1'b1;
    @(negedge clk);
    chk("rst re pre-edge", fif.read_enable, 0);
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst serial_out", serial_out, 1);
      chk("rst tx_busy", tx_busy, 0);
      chk("rst read_enable", fif.read_enable, 0);
      chk("rst bit_strobe", bit_strobe, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // 0x00: byte already queued across reset
    fq.delete();
    mb = '{8'h00};
    start_scn(0, 0);
    chk("00 pops", n_re, 1);
    chk("00 busy cycles", n_busy, 64);
    chk("00 strobes", n_stb, 8);
    chk("00 model c1", exp_ser[1], 0);
    chk("00 model c9", exp_ser[9], 1);

    // 0xFF: six 1s then a stuffed 0
    mb = '{8'hFF};
    start_scn(0, 0);
    chk("FF pops", n_re, 1);
    chk("FF busy cycles", n_busy, 72);
    chk("FF strobes", n_stb, 9);
    chk("FF model c48", exp_ser[48], 1);
    chk("FF model c49", exp_ser[49], 0);
    chk("FF model c72", exp_ser[72], 0);

    // 0x0F, 0xF0 back-to-back
    mb = '{8'h0F, 8'hF0};
    start_scn(0, 0);
    chk("0F/F0 pops", n_re, 2);
    chk("0F/F0 busy cycles", n_busy, 128);
    chk("0F/F0 strobes", n_stb, 16);
    chk("0F/F0 model pop c64", exp_re[64], 1);

    // 0xFC, 0x01: trailing stuff bit before second byte
    mb = '{8'hFC, 8'h01};
    start_scn(0, 0);
    chk("FC/01 pops", n_re, 2);
    chk("FC/01 busy cycles", n_busy, 136);
    chk("FC/01 strobes", n_stb, 17);
    chk("FC/01 model pop c72", exp_re[72], 1);
    chk("FC/01 model stuff c72", exp_ser[72], 1);
    chk("FC/01 model hold c80", exp_ser[80], 1);

    // tx_enable dropped mid-byte: current byte finishes, second stays queued
    mb = '{8'h81};
    fq.push_back(8'h81);
    start_scn(20, 0);
    chk("drop pops", n_re, 1);
    chk("drop busy cycles", n_busy, 64);
    chk("drop left in fifo", fq.size(), 1);
    fq.delete();
    drive_fifo();

    // Reset during bit 3 of 0xA5
    mb = '{8'hA5};
    start_scn(0, 27);
    rst = 1'b0;
    line_lvl = 1'b1;
    tx_enable = 1'b1;
    @(negedge clk);
    chk("midrst serial_out", serial_out, 1);
    chk("midrst tx_busy", tx_busy, 0);
    chk("midrst bit_strobe", bit_strobe, 0);
    n_re = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (fif.read_enable === 1'b1) n_re++;
    end
    chk("midrst no re-read", n_re, 0);
    chk("midrst fifo drained", fq.size(), 0);
    @(posedge clk); #1;
    fq.push_back(8'h3C);
    drive_fifo();
    @(negedge clk);
    chk("midrst new write pops", fif.read_enable, 1);
    @(posedge clk); #1;
    tx_enable = 1'b0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_nrzi_serializer.md
Name: tx_nrzi_serializer

Overview:
- Drains bytes from the upstream transmit FIFO (8-bit, first-word-fall-through) and serializes them LSB-first onto a single line.
- Applies bit stuffing: a forced 0 after STUFF_LIMIT consecutive 1s.
- Applies NRZI encoding: a 0 toggles the line, a 1 holds it.
- Sits directly downstream of tx_fifo; it is the only consumer of the FIFO read port.

Parameters:
- DATA_WIDTH, 8, byte width; must match the FIFO data width.
- CLKS_PER_BIT, 8, clk cycles per line bit period (≥2).
- STUFF_LIMIT, 6, consecutive 1s that trigger insertion of a stuff 0.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- tx_enable  in  1  permission to start or continue popping bytes
- fifo_empty  in  1  FIFO empty flag
- read_data  in  DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0
- read_enable  out  1  one-cycle pop strobe to the FIFO; combinational from state
- serial_out  out  1  NRZI-encoded line, registered
- bit_strobe  out  1  high in the first cycle of every bit period (data or stuff), registered
- tx_busy  out  1  high whenever state≠IDLE

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high.
- Reset values: serial_out=1, bit_strobe=0, tx_busy=0, read_enable=0, state=IDLE, ones_cnt=0, bit_idx=0, clk_cnt=0.
- States: IDLE, SHIFT (sending data bits), STUFF (sending an inserted 0).
- IDLE:
  - serial_out holds its level; ones_cnt is held at 0.
  - If tx_enable=1 and fifo_empty=0: read_enable=1 this cycle, shift_reg<=read_data, bit_idx<=0, go to SHIFT.
- Line timing:
  - Bit level is applied on the edge that enters a bit period.
  - So bit 0 appears on serial_out the cycle after the read_enable pulse (1-cycle latency).
  - Each bit period lasts exactly CLKS_PER_BIT cycles; clk_cnt counts 0..CLKS_PER_BIT-1.
- Encoding rule, applied on entry to each period:
  - bit 0: serial_out<=~serial_out, ones_cnt<=0.
  - bit 1: serial_out holds, ones_cnt<=ones_cnt+1.
  - A stuff bit is a 0.
- End of a data period (clk_cnt=CLKS_PER_BIT-1), checked in this priority order:
  1. ones_cnt==STUFF_LIMIT → go to STUFF.
  2. Else if bit_idx<DATA_WIDTH-1 → next bit.
  3. Else if tx_enable && !fifo_empty → pop in this same cycle and start the next byte back-to-back with no gap; ones_cnt carries over.
  4. Otherwise → IDLE.
- End of a STUFF period:
  - If bits remain in the byte, continue with the next bit.
  - If the byte is finished, apply the same pop-or-IDLE decision as above.
  - A stuff bit owed after the last data bit is always sent before the next byte or before IDLE.
- read_enable:
  - Never asserted when fifo_empty=1.
  - Never asserted more than once per byte.
  - Never asserted during rst.
- tx_enable deasserted mid-byte: the current byte and any pending stuff bit complete, then IDLE.
- rst mid-operation: all state returns to reset values on the next edge; the in-flight byte is discarded, not re-read.
- Width rules:
  - ones_cnt is $clog2(STUFF_LIMIT+1) bits and saturates by construction.
  - bit_idx is $clog2(DATA_WIDTH) bits.

Decomposition:
- Shared package tx_pkg holds:
  - state enum {IDLE, SHIFT, STUFF};
  - defaults for DATA_WIDTH, CLKS_PER_BIT, STUFF_LIMIT;
  - constant LINE_IDLE=1'b1.
- Sub-module tx_bit_timer: counter with clear and enable.
  - Outputs period_start (drives bit_strobe) and period_end (advances the FSM).
- All other logic (FSM, shifter, NRZI, stuffing) stays in tx_nrzi_serializer.

Test Plan:
- Reset held 2 cycles with fifo_empty=0, tx_enable=1 → serial_out=1, tx_busy=0, read_enable=0 throughout reset.
- Send one byte 0x00 → exactly one read_enable pulse; serial_out toggles every 8 cycles: 0,1,0,1,0,1,0,1; tx_busy drops after 64 cycles.
- Send one byte 0xFF → line stays 1 for 48 cycles, then drops to 0 for the 8-cycle stuff period, then stays 0 for 2 more bits; 72 busy cycles, 9 bit_strobe pulses.
- Send 0x0F then 0xF0 with both already queued → second read_enable occurs in the last cycle of byte 1 bit 7; no idle cycle; 128 cycles total; no stuffing.
- Send 0xFC then 0x01 → after byte 1 (six trailing 1s) a stuff period is inserted; the second pop occurs in the last cycle of the stuff period; byte 2 bit 0 (1) holds the line.
- Assert rst for 1 cycle during bit 3 of 0xA5 with the FIFO then empty → next cycle serial_out=1, tx_busy=0, bit_strobe=0; no further read_enable until a new write.
